if_seq_ctrl: RTL and testbench
==============================

Name: if_seq_ctrl

Overview:
- Sequencer for the instruction-fetch stage: owns the program counter update (newPC) and the instruction-memory write port (WE/W_Ins).
- Phase 1 (LOAD) streams a program into instruction memory over a valid/ready handshake.
- Phase 2 (RUN) drives the next PC each cycle, arbitrating redirect, stall and sequential increment.
- Sits between the boot/host interface, the hazard/branch unit and the IF stage.

Parameters:
- AW, 10, instruction-memory word-address width (depth = 2^AW words).
- RESET_PC, 32'h0000_0000, PC issued on the first RUN cycle; must be word-aligned.
- MAX_WORDS, 1024, load word limit; must be ≤ 2^AW.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  pulse in IDLE: begin LOAD.
- ld_valid  in  1  load word valid.
- ld_data  in  32  load word.
- ld_last  in  1  qualifies final load word.
- ld_ready  out  1  controller accepts load word.
- im_we  out  1  instruction-memory write enable.
- im_waddr  out  AW  instruction-memory word address.
- im_wdata  out  32  instruction-memory write data.
- stall  in  1  hold PC (hazard unit).
- redirect  in  1  branch/jump taken.
- redirect_pc  in  32  redirect target.
- halt_req  in  1  stop fetching.
- new_pc  out  32  next PC to IF stage.
- fetch_en  out  1  IF stage may fetch.
- busy  out  1  state is LOAD or RUN.
- err  out  1  sticky misaligned-redirect flag.
- state_o  out  2  IDLE=0, LOAD=1, RUN=2, HALT=3.

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; new_pc=RESET_PC; word counter=0; all other outputs 0. Reset asserted mid-LOAD or mid-RUN aborts immediately; partially written memory contents are not cleared.
- IDLE: ld_ready=0, fetch_en=0. start=1 → LOAD, word counter cleared.
- LOAD:
  - ld_ready=1.
  - On ld_valid & ld_ready, register im_we=1, im_waddr=counter, im_wdata=ld_data, so the write appears one cycle after the handshake.
  - Counter increments per accepted word.
  - When the accepted word has ld_last=1, or the counter reaches MAX_WORDS-1, go to RUN next cycle. ld_ready is 0 in that next cycle.
  - im_we is never high for more than one cycle per accepted word.
  - Counter never wraps: a word beyond MAX_WORDS is impossible by construction.
  - start is ignored outside IDLE.
- RUN:
  - First cycle: new_pc=RESET_PC, fetch_en=1.
  - Each following cycle, new_pc is updated with this priority: halt_req (→ HALT, new_pc held) > redirect (new_pc ← redirect_pc) > stall (new_pc held) > new_pc+4.
  - The +4 is modulo 2^32: 32'hFFFF_FFFC wraps to 0.
  - redirect with redirect_pc[1:0]≠0 → err=1 (sticky), state → HALT, new_pc held.
  - redirect and stall in the same cycle: redirect wins.
- HALT: fetch_en=0, new_pc held. start=1 → LOAD with err cleared; RUN is not re-entered without a reload.
- busy = (state==LOAD)|(state==RUN).
- im_we=0 outside LOAD, except for the final registered write, which is permitted one cycle into RUN.

Decomposition:
- Shared package: state encoding constants, RESET_PC default, instruction word width (32).
- One sub-module is natural: if_pc_next, purely combinational; computes next PC from (pc, stall, redirect, redirect_pc, halt_req) and the misalign flag.

Test Plan:
- Reset then start, stream 3 words 0x20080005, 0x20090003, 0x01095020 (last on third) → im_we pulses at addr 0, 1, 2 with those data; state RUN; new_pc sequence 0, 4, 8, 12.
- ld_valid gapped (valid every other cycle) for 2 words → exactly 2 im_we pulses, addresses 0 and 1, no duplicates.
- RUN, redirect=1 with redirect_pc=0x40 and stall=1 in the same cycle → next new_pc=0x40; the following cycle stall=1 alone holds 0x40.
- RUN, redirect_pc=0x42 → err=1, state HALT, fetch_en=0, new_pc unchanged; then start → LOAD with err=0.
- RUN with new_pc=0xFFFF_FFFC, no stall → new_pc=0x0000_0000.
- RST pulled low mid-LOAD after 2 words → asynchronously state IDLE, new_pc=RESET_PC, outputs 0; after release, start reloads from address 0.

Source files
------------

// File: rtl/if_seq_ctrl_pkg.sv
// if_seq_ctrl_pkg: shared state encoding, instruction width and reset PC for the fetch sequencer
package if_seq_ctrl_pkg;
   localparam int IW = 32;
   localparam logic [IW-1:0] RESET_PC_DEF = 32'h0000_0000;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_HALT = 2'd3
   } state_t;
endpackage

// File: rtl/if_seq_ctrl_pc_next.sv
// if_seq_ctrl_pc_next: combinational next-PC arbitration (halt > redirect > stall > +4)
//   pc, stall, redirect, redirect_pc, halt_req -> pc_nxt, misalign, go_halt
module if_seq_ctrl_pc_next
   import if_seq_ctrl_pkg::*;
(
   input  logic [IW-1:0] pc,
   input  logic          stall,
   input  logic          redirect,
   input  logic [IW-1:0] redirect_pc,
   input  logic          halt_req,
   output logic [IW-1:0] pc_nxt,
   output logic          misalign,
   output logic          go_halt
);
   // a misaligned target only counts when the redirect is not pre-empted by halt
   assign misalign = redirect & ~halt_req & (|redirect_pc[1:0]);
   assign go_halt  = halt_req | misalign;
   assign pc_nxt   = go_halt ? pc : redirect ? redirect_pc : stall ? pc : pc + 32'd4;
endmodule

// File: rtl/if_seq_ctrl.sv
// if_seq_ctrl: IF-stage sequencer; loads a program into instruction memory then drives the PC
//   CLK/RST (async active-low); start; ld_valid/ld_data/ld_last/ld_ready load handshake;
//   im_we/im_waddr/im_wdata memory write port; stall/redirect/redirect_pc/halt_req PC control;
//   new_pc, fetch_en, busy, err (sticky misaligned redirect), state_o
module if_seq_ctrl
   import if_seq_ctrl_pkg::*;
#(
   parameter int             AW        = 10,
   parameter logic [IW-1:0]  RESET_PC  = RESET_PC_DEF,
   parameter int             MAX_WORDS = 1024
)(
   input  logic          CLK,
   input  logic          RST,
   input  logic          start,
   input  logic          ld_valid,
   input  logic [IW-1:0] ld_data,
   input  logic          ld_last,
   output logic          ld_ready,
   output logic          im_we,
   output logic [AW-1:0] im_waddr,
   output logic [IW-1:0] im_wdata,
   input  logic          stall,
   input  logic          redirect,
   input  logic [IW-1:0] redirect_pc,
   input  logic          halt_req,
   output logic [IW-1:0] new_pc,
   output logic          fetch_en,
   output logic          busy,
   output logic          err,
   output logic [1:0]    state_o
);
   localparam logic [AW-1:0] LAST_W = AW'(MAX_WORDS - 1);
   state_t        state_q, state_d;
   logic [AW-1:0] cnt;
   logic [IW-1:0] pc_nxt;
   logic          misalign, go_halt, accept;
   assign ld_ready = state_q == S_LOAD;
   assign accept   = ld_valid & ld_ready;
   assign fetch_en = state_q == S_RUN;
   assign busy     = (state_q == S_LOAD) | (state_q == S_RUN);
   assign state_o  = state_q;
   if_seq_ctrl_pc_next u_pc_next (
      .pc          (new_pc),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt_req    (halt_req),
      .pc_nxt      (pc_nxt),
      .misalign    (misalign),
      .go_halt     (go_halt)
   );
   always_ff @(posedge CLK or negedge RST)
      if (!RST) state_q <= S_IDLE;
      else      state_q <= state_d;
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_LOAD;
         S_LOAD:  if (accept && (ld_last || cnt == LAST_W)) state_d = S_RUN;
         S_RUN:   if (go_halt) state_d = S_HALT;
         S_HALT:  if (start) state_d = S_LOAD;
         default: state_d = S_IDLE;
      endcase
   end
   // the write is registered, so the last word lands one cycle into RUN
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         cnt      <= '0;
         im_we    <= 1'b0;
         im_waddr <= '0;
         im_wdata <= '0;
         new_pc   <= RESET_PC;
         err      <= 1'b0;
      end else begin
         im_we <= accept;
         if (accept) begin
            im_waddr <= cnt;
            im_wdata <= ld_data;
            cnt      <= cnt + AW'(1);
         end
         if (state_q != S_LOAD && state_d == S_LOAD) begin
            cnt <= '0;
            err <= 1'b0;
         end
         if (state_q == S_LOAD && state_d == S_RUN) new_pc <= RESET_PC;
         if (state_q == S_RUN) begin
            new_pc <= pc_nxt;
            if (misalign) err <= 1'b1;
         end
      end
endmodule

// File: tb/tb_if_seq_ctrl.sv
// tb_if_seq_ctrl: directed self-checking bench with a write scoreboard for if_seq_ctrl
module tb_if_seq_ctrl;
   logic        CLK = 1'b0, RST = 1'b0;
   logic        start = 0, ld_valid = 0, ld_last = 0, stall = 0, redirect = 0, halt_req = 0;
   logic [31:0] ld_data = 0, redirect_pc = 0;
   logic        ld_ready, im_we, fetch_en, busy, err;
   logic [9:0]  im_waddr;
   logic [31:0] im_wdata, new_pc;
   logic [1:0]  state_o;
   int          checks = 0, failures = 0;
   logic [9:0]  exp_addr = 0;
   logic [41:0] sb[$];

   if_seq_ctrl dut (
      .CLK(CLK), .RST(RST), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_last(ld_last), .ld_ready(ld_ready), .im_we(im_we), .im_waddr(im_waddr),
      .im_wdata(im_wdata), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .halt_req(halt_req), .new_pc(new_pc), .fetch_en(fetch_en), .busy(busy), .err(err),
      .state_o(state_o)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input logic last);
      chk("ld_ready_at_send", {31'd0, ld_ready}, 32'd1);
      ld_valid = 1; ld_data = d; ld_last = last;
      sb.push_back({exp_addr, d});
      exp_addr++;
      tick();
      ld_valid = 0; ld_last = 0;
   endtask

   task automatic do_start();
      start = 1; exp_addr = 0;
      tick();
      start = 0;
   endtask

   always @(negedge CLK) begin
      logic [41:0] e;
      if (RST && im_we) begin
         checks++;
         assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL im_we_unexpected observed=addr %h data %h expected=no write", im_waddr, im_wdata);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("im_waddr", {22'd0, im_waddr}, {22'd0, e[41:32]});
            chk("im_wdata", im_wdata, e[31:0]);
         end
      end
   end

   initial begin
      tick();
      chk("rst_state", {30'd0, state_o}, 32'd0);
      chk("rst_new_pc", new_pc, 32'd0);
      chk("rst_outs", {27'd0, ld_ready, im_we, fetch_en, busy, err}, 32'd0);
      RST = 1;
      tick();
      // load three words, last on the third
      do_start();
      chk("load_state", {30'd0, state_o}, 32'd1);
      chk("load_busy", {31'd0, busy}, 32'd1);
      send(32'h2008_0005, 0);
      send(32'h2009_0003, 0);
      send(32'h0109_5020, 1);
      chk("run_state", {30'd0, state_o}, 32'd2);
      chk("run_ready_low", {31'd0, ld_ready}, 32'd0);
      chk("run_fetch_en", {31'd0, fetch_en}, 32'd1);
      chk("run_pc0", new_pc, 32'd0);
      tick(); chk("run_pc4", new_pc, 32'd4);
      tick(); chk("run_pc8", new_pc, 32'd8);
      tick(); chk("run_pc12", new_pc, 32'd12);
      chk("sb_empty_1", sb.size(), 32'd0);
      // redirect beats stall, then stall alone holds
      redirect = 1; redirect_pc = 32'h40; stall = 1;
      tick(); chk("redir_over_stall", new_pc, 32'h40);
      redirect = 0;
      tick(); chk("stall_hold", new_pc, 32'h40);
      stall = 0;
      tick(); chk("inc_after_stall", new_pc, 32'h44);
      // wrap at top of address space
      redirect = 1; redirect_pc = 32'hFFFF_FFFC;
      tick(); chk("redir_top", new_pc, 32'hFFFF_FFFC);
      redirect = 0;
      tick(); chk("pc_wrap", new_pc, 32'h0);
      tick(); chk("pc_after_wrap", new_pc, 32'h4);
      // misaligned redirect
      redirect = 1; redirect_pc = 32'h42;
      tick();
      redirect = 0;
      chk("mis_err", {31'd0, err}, 32'd1);
      chk("mis_state", {30'd0, state_o}, 32'd3);
      chk("mis_fetch_en", {31'd0, fetch_en}, 32'd0);
      chk("mis_pc_held", new_pc, 32'h4);
      chk("mis_busy", {31'd0, busy}, 32'd0);
      tick(); chk("halt_sticky_err", {31'd0, err}, 32'd1);
      // reload from HALT with gapped valid
      do_start();
      chk("reload_state", {30'd0, state_o}, 32'd1);
      chk("reload_err_clr", {31'd0, err}, 32'd0);
      send(32'h0000_00AA, 0);
      tick();
      send(32'h0000_00BB, 1);
      chk("gap_run_state", {30'd0, state_o}, 32'd2);
      chk("gap_run_pc", new_pc, 32'd0);
      tick();
      chk("sb_empty_2", sb.size(), 32'd0);
      // halt_req beats redirect
      halt_req = 1; redirect = 1; redirect_pc = 32'h80;
      tick();
      halt_req = 0; redirect = 0;
      chk("halt_state", {30'd0, state_o}, 32'd3);
      chk("halt_pc_held", new_pc, 32'd4);
      chk("halt_no_err", {31'd0, err}, 32'd0);
      // async reset mid-load
      do_start();
      send(32'h1111_1111, 0);
      send(32'h2222_2222, 0);
      tick();
      #2 RST = 0;
      #1;
      chk("arst_state", {30'd0, state_o}, 32'd0);
      chk("arst_pc", new_pc, 32'd0);
      chk("arst_outs", {27'd0, ld_ready, im_we, fetch_en, busy, err}, 32'd0);
      tick();
      RST = 1;
      tick();
      do_start();
      send(32'h3333_3333, 1);
      chk("rl_run_state", {30'd0, state_o}, 32'd2);
      tick();
      chk("sb_empty_3", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
